// File: rtl/fp_addsub_pipe_if.sv
// Handshake bundle for the pipelined floating-point adder/subtractor.
// The producer/consumer side uses master; the arithmetic block uses slave.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag, out_flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Five-stage IEEE-754-style add/subtract with RNE rounding, flush-to-zero
// denormals, special-value bypass and a global-stall valid/ready handshake.
// All state updates on the falling edge of clk_n; rst_n is an active-high
// asynchronous clear.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic             clk_n,
    input  logic             rst_n,
    fp_addsub_pipe_if.slave  bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;          // mantissa with hidden bit
    localparam int SW   = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
    localparam int LZ_W = $clog2(SW + 1);
    localparam int XW   = EXP_W + 2;          // signed working exponent
    localparam logic [EXP_W-1:0]        EXP_MAX = '1;
    localparam logic signed [XW-1:0]    EXP_ONE = 1;
    localparam logic signed [XW-1:0]    EXP_TOP = {2'b00, EXP_MAX};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    function automatic logic [W-1:0] sat_inf(input logic sgn);
        return {sgn, EXP_MAX, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [LZ_W-1:0] lzc(input logic [SW-1:0] v);
        logic            found;
        logic [LZ_W-1:0] n;
        found = 1'b0;
        n     = '0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + {{(LZ_W-1){1'b0}}, 1'b1};
            end
        end
        return n;
    endfunction

    logic vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
    logic adv;

    assign adv          = bus.out_ready | ~vld_p5;
    assign bus.in_ready = adv;

    // S1 combinational: unpack, classify, special-value decision, magnitude swap
    logic             sa, sb, eff_sub, a_big;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             spec_s1, inv_s1;
    logic [W-1:0]     spec_res_s1;

    assign sa      = bus.in_a[W-1];
    assign sb      = bus.in_b[W-1] ^ bus.in_sub;
    assign ea      = bus.in_a[W-2 -: EXP_W];
    assign eb      = bus.in_b[W-2 -: EXP_W];
    assign ma      = bus.in_a[MAN_W-1:0];
    assign mb      = bus.in_b[MAN_W-1:0];
    assign a_nan   = (ea == EXP_MAX) && (ma != '0);
    assign b_nan   = (eb == EXP_MAX) && (mb != '0);
    assign a_inf   = (ea == EXP_MAX) && (ma == '0);
    assign b_inf   = (eb == EXP_MAX) && (mb == '0);
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign eff_sub = sa ^ sb;
    assign a_big   = {ea, ma} >= {eb, mb};

    // Specials resolve here and ride down the pipe untouched by the arithmetic
    always_comb begin
        spec_s1     = 1'b1;
        inv_s1      = 1'b0;
        spec_res_s1 = '0;
        if (a_nan || b_nan) begin
            spec_res_s1 = QNAN;
            inv_s1      = (a_nan & ~ma[MAN_W-1]) | (b_nan & ~mb[MAN_W-1]);
        end else if (a_inf && b_inf) begin
            spec_res_s1 = eff_sub ? QNAN : sat_inf(sa);
            inv_s1      = eff_sub;
        end else if (a_inf) begin
            spec_res_s1 = sat_inf(sa);
        end else if (b_inf) begin
            spec_res_s1 = sat_inf(sb);
        end else if (b_zero) begin
            spec_res_s1 = a_zero ? {sa & sb, {(W-1){1'b0}}} : bus.in_a;
        end else if (a_zero) begin
            spec_res_s1 = {sb, eb, mb};
        end else begin
            spec_s1 = 1'b0;
        end
    end

    logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3, tag_p4, tag_p5;
    logic             spec_p1, spec_p2, spec_p3, spec_p4;
    logic             inv_p1, inv_p2, inv_p3, inv_p4;
    logic [W-1:0]     sres_p1, sres_p2, sres_p3, sres_p4;
    logic             sign_p1, sign_p2, sign_p3, sign_p4;
    logic             esub_p1, esub_p2;
    logic [EXP_W-1:0] exp_p1, exp_p2, exp_p3;
    logic [MW-1:0]    mbig_p1, msml_p1;
    logic [EXP_W-1:0] diff_p1;

    // S1 register: classified, swapped operands
    always_ff @(negedge clk_n or posedge rst_n) begin
        if (rst_n) begin
            vld_p1 <= 1'b0; tag_p1 <= '0; spec_p1 <= 1'b0; inv_p1 <= 1'b0; sres_p1 <= '0;
            sign_p1 <= 1'b0; esub_p1 <= 1'b0; exp_p1 <= '0; mbig_p1 <= '0; msml_p1 <= '0; diff_p1 <= '0;
        end else if (adv) begin
            vld_p1  <= bus.in_valid;
            tag_p1  <= bus.in_tag;
            spec_p1 <= spec_s1;
            inv_p1  <= inv_s1;
            sres_p1 <= spec_res_s1;
            sign_p1 <= a_big ? sa : sb;
            esub_p1 <= eff_sub;
            exp_p1  <= a_big ? ea : eb;
            mbig_p1 <= a_big ? {1'b1, ma} : {1'b1, mb};
            msml_p1 <= a_big ? {1'b1, mb} : {1'b1, ma};
            diff_p1 <= a_big ? (ea - eb) : (eb - ea);
        end
    end

    // S2 combinational: align small operand, shifted-out bits collapse into sticky
    logic [SW-1:0] sml_ext, sml_shf;
    always_comb begin
        sml_ext = {msml_p1, 3'b000};
        if (32'(diff_p1) >= MAN_W + 3) begin
            sml_shf    = '0;
            sml_shf[0] = |msml_p1;
        end else begin
            sml_shf    = sml_ext >> diff_p1;
            sml_shf[0] = sml_shf[0] | (|(sml_ext & ~({SW{1'b1}} << diff_p1)));
        end
    end

    logic [SW-1:0] big_p2, sml_p2;

    // S2 register: aligned mantissas
    always_ff @(negedge clk_n or posedge rst_n) begin
        if (rst_n) begin
            vld_p2 <= 1'b0; tag_p2 <= '0; spec_p2 <= 1'b0; inv_p2 <= 1'b0; sres_p2 <= '0;
            sign_p2 <= 1'b0; esub_p2 <= 1'b0; exp_p2 <= '0; big_p2 <= '0; sml_p2 <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1; tag_p2 <= tag_p1; spec_p2 <= spec_p1; inv_p2 <= inv_p1; sres_p2 <= sres_p1;
            sign_p2 <= sign_p1; esub_p2 <= esub_p1; exp_p2 <= exp_p1;
            big_p2  <= {mbig_p1, 3'b000};
            sml_p2  <= sml_shf;
        end
    end

    logic [SW:0] sum_p3;

    // S3 register: magnitude add or subtract (big >= small, so never negative)
    always_ff @(negedge clk_n or posedge rst_n) begin
        if (rst_n) begin
            vld_p3 <= 1'b0; tag_p3 <= '0; spec_p3 <= 1'b0; inv_p3 <= 1'b0; sres_p3 <= '0;
            sign_p3 <= 1'b0; exp_p3 <= '0; sum_p3 <= '0;
        end else if (adv) begin
            vld_p3 <= vld_p2; tag_p3 <= tag_p2; spec_p3 <= spec_p2; inv_p3 <= inv_p2; sres_p3 <= sres_p2;
            sign_p3 <= sign_p2; exp_p3 <= exp_p2;
            sum_p3  <= esub_p2 ? ({1'b0, big_p2} - {1'b0, sml_p2}) : ({1'b0, big_p2} + {1'b0, sml_p2});
        end
    end

    // S4 combinational: carry right-shift or leading-zero left-shift; zero sum leaves norm=0
    logic [LZ_W-1:0]        lz;
    logic [SW-1:0]          norm_s4;
    logic signed [XW-1:0]   exp_s4;
    always_comb begin
        lz      = lzc(sum_p3[SW-1:0]);
        norm_s4 = '0;
        exp_s4  = '0;
        if (sum_p3[SW]) begin
            norm_s4    = sum_p3[SW:1];
            norm_s4[0] = sum_p3[1] | sum_p3[0];
            exp_s4     = $signed({2'b00, exp_p3}) + EXP_ONE;
        end else if (sum_p3 != '0) begin
            norm_s4 = sum_p3[SW-1:0] << lz;
            exp_s4  = $signed({2'b00, exp_p3}) - $signed({{(XW-LZ_W){1'b0}}, lz});
        end
    end

    logic [SW-1:0]        norm_p4;
    logic signed [XW-1:0] exp_p4;

    // S4 register: normalised mantissa with guard/round/sticky
    always_ff @(negedge clk_n or posedge rst_n) begin
        if (rst_n) begin
            vld_p4 <= 1'b0; tag_p4 <= '0; spec_p4 <= 1'b0; inv_p4 <= 1'b0; sres_p4 <= '0;
            sign_p4 <= 1'b0; exp_p4 <= '0; norm_p4 <= '0;
        end else if (adv) begin
            vld_p4 <= vld_p3; tag_p4 <= tag_p3; spec_p4 <= spec_p3; inv_p4 <= inv_p3; sres_p4 <= sres_p3;
            sign_p4 <= sign_p3; exp_p4 <= exp_s4; norm_p4 <= norm_s4;
        end
    end

    // S5 combinational: RNE on the fraction, then zero/underflow/overflow packing
    logic [MAN_W:0]       frac_r;
    logic signed [XW-1:0] exp_r;
    logic                 inexact;
    logic [W-1:0]         res_s5;
    logic [3:0]           flags_s5;
    always_comb begin
        frac_r  = {1'b0, norm_p4[SW-2:3]}
                + {{MAN_W{1'b0}}, rne_up(norm_p4[3], norm_p4[2], norm_p4[1], norm_p4[0])};
        exp_r   = exp_p4 + $signed({{(XW-1){1'b0}}, frac_r[MAN_W]});
        inexact = norm_p4[2] | norm_p4[1] | norm_p4[0];
        if (spec_p4) begin
            res_s5   = sres_p4;
            flags_s5 = {inv_p4, 3'b000};
        end else if (!norm_p4[SW-1]) begin
            res_s5   = '0;
            flags_s5 = 4'b0000;
        end else if (exp_p4 < EXP_ONE) begin
            res_s5   = {sign_p4, {(W-1){1'b0}}};
            flags_s5 = 4'b0011;
        end else if (exp_r >= EXP_TOP) begin
            res_s5   = sat_inf(sign_p4);
            flags_s5 = 4'b0101;
        end else begin
            res_s5   = {sign_p4, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
            flags_s5 = {3'b000, inexact};
        end
    end

    logic [W-1:0] res_p5;
    logic [3:0]   flags_p5;

    // S5 register: packed result, held while the consumer stalls
    always_ff @(negedge clk_n or posedge rst_n) begin
        if (rst_n) begin
            vld_p5 <= 1'b0; tag_p5 <= '0; res_p5 <= '0; flags_p5 <= '0;
        end else if (adv) begin
            vld_p5 <= vld_p4; tag_p5 <= tag_p4; res_p5 <= res_s5; flags_p5 <= flags_s5;
        end
    end

    assign bus.out_valid = vld_p5;
    assign bus.out_res   = res_p5;
    assign bus.out_tag   = tag_p5;
    assign bus.out_flags = flags_p5;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe in its FP32 configuration.
module tb_fp_addsub_pipe;
    logic clk_n = 1'b1;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_n = ~clk_n;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk_n (clk_n),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    logic [31:0] fint [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [3:0] tag);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_tag   = tag;
    endtask

    // One isolated op: checks latency, result, flags and tag
    task automatic run_vec(input int idx);
        int edges;
        @(posedge clk_n);
        drive(1'b1, vecs[idx].a, vecs[idx].b, vecs[idx].sub, 4'(idx));
        #1;
        check($sformatf("vec%0d in_ready", idx), {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk_n);
        edges = 1;
        @(posedge clk_n);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && edges < 12) begin
            @(negedge clk_n);
            edges++;
            @(posedge clk_n);
        end
        check($sformatf("vec%0d latency", idx), 32'(edges), 32'd5);
        check($sformatf("vec%0d res", idx), bus.out_res, vecs[idx].res);
        check($sformatf("vec%0d flags", idx), {28'b0, bus.out_flags}, {28'b0, vecs[idx].flags});
        check($sformatf("vec%0d tag", idx), {28'b0, bus.out_tag}, 32'(idx[3:0]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued, got, stalls, seen;
        logic held;
        logic [31:0] held_res;
        logic [3:0]  held_tag;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[3]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
        vecs[6]  = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000};
        vecs[7]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[9]  = '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 4'b0000};
        vecs[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[12] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
        vecs[13] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000};
        vecs[14] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011};
        vecs[15] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        vecs[16] = '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[17] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000};

        fint = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk_n);
        @(negedge clk_n);
        @(posedge clk_n);
        #1;
        check("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst out_res", bus.out_res, 32'h0);
        check("rst out_tag", {28'b0, bus.out_tag}, 32'h0);
        check("rst out_flags", {28'b0, bus.out_flags}, 32'h0);
        check("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
        rst_n = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Stream of 8 tagged ops with a 3-edge consumer stall mid-stream
        issued = 0; got = 0; stalls = 0; held = 1'b0; held_res = '0; held_tag = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_n);
            bus.out_ready = !(c >= 5 && c <= 7);
            if (issued < 8) drive(1'b1, fint[issued], 32'h3F800000, 1'b0, 4'(issued));
            else            bus.in_valid = 1'b0;
            #1;
            if (held) begin
                check($sformatf("stall hold res c%0d", c), bus.out_res, held_res);
                check($sformatf("stall hold tag c%0d", c), {28'b0, bus.out_tag}, {28'b0, held_tag});
            end
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                check($sformatf("stall in_ready c%0d", c), {31'b0, bus.in_ready}, 32'd0);
                held = 1'b1; held_res = bus.out_res; held_tag = bus.out_tag;
            end else begin
                held = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (got < 8) begin
                    check($sformatf("stream res %0d", got), bus.out_res, fint[got+1]);
                    check($sformatf("stream tag %0d", got), {28'b0, bus.out_tag}, 32'(got));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) issued++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream result count", 32'(got), 32'd8);
        check("stream stall edges", 32'(stalls), 32'd3);

        // Reset with three ops in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_n);
            drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'(9 + k));
        end
        @(posedge clk_n);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_n);
        @(posedge clk_n);
        #1;
        check("midrst out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst out_res", bus.out_res, 32'h0);
        rst_n = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_n);
            #1;
            if (bus.out_valid) seen++;
        end
        check("midrst stale outputs", 32'(seen), 32'd0);
        run_vec(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
